motor_duty_sequencer: RTL and testbench
=======================================

Name: motor_duty_sequencer

Overview:
- Parametrised N-channel successor to the per-wheel duty-cycle update logic.
- On each control-rate strobe, snapshots every channel's PID correction and measured RPM, then processes channels one per cycle (signed add, slew limit, min/max saturation), then emits one telemetry record per channel to a downstream FIFO/UART path.
- Sits between the pid_controller instances and the pwm instances.

Parameters:
NUM_CH, 2, number of motor channels (1..256)
PWM_RESOLUTION, 16, duty width in bits (<=16)
RPM_RESOLUTION, 10, measured RPM width in bits (<=16)
DUTY_INIT, 27000, duty loaded at reset and while motors are disabled
DUTY_MIN, 0, lower saturation bound
DUTY_MAX, 49151, upper saturation bound (75% of full scale)
SLEW_MAX, 4096, maximum correction magnitude applied per update

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
update_en  in  1  single-cycle control-rate clock-enable strobe
motor_en  in  1  motor enable switch
correction  in  NUM_CH*(PWM_RESOLUTION+1)  packed signed per-channel corrections; ch k at [k*(PWM_RESOLUTION+1) +: PWM_RESOLUTION+1]
rpm_measured  in  NUM_CH*RPM_RESOLUTION  packed unsigned measured RPM
duty_out  out  NUM_CH*PWM_RESOLUTION  packed unsigned duty to pwm
sat_hi  out  NUM_CH  channel clamped at DUTY_MAX on its last update
sat_lo  out  NUM_CH  channel clamped at DUTY_MIN on its last update
slew_hit  out  NUM_CH  channel correction limited by SLEW_MAX on its last update
busy  out  1  high when FSM is not IDLE
overrun  out  1  sticky; update_en seen while busy
tlm_full  in  1  downstream FIFO full
tlm_wr_en  out  1  telemetry write strobe
tlm_din  out  64  telemetry record
tlm_drop_cnt  out  16  records dropped due to tlm_full, saturating at 65535

Behaviour:
- Reset: every duty_out lane = DUTY_INIT; all flags, busy, overrun, tlm_wr_en, tlm_drop_cnt = 0; tlm_din = 0; FSM in IDLE. Reset asserted in any state aborts the operation with identical results.
- FSM states: IDLE, UPDATE, LOG.
- IDLE: if update_en is high at cycle t:
  - snapshot all correction and rpm_measured lanes;
  - channel index = 0;
  - go to UPDATE.
- UPDATE (cycles t+1 .. t+NUM_CH): channel k is processed in cycle t+1+k, and new duty_out[k] is visible from t+2+k.
  - Slew: c' = clamp(correction_k, -SLEW_MAX, +SLEW_MAX). slew_hit[k] = 1 if c' != correction_k.
  - Add: s = {0,duty_k} + c', computed in PWM_RESOLUTION+2 signed bits, with no wrap.
  - Saturate:
    - s > DUTY_MAX: duty = DUTY_MAX, sat_hi[k] = 1.
    - s < DUTY_MIN: duty = DUTY_MIN, sat_lo[k] = 1.
    - Otherwise duty = s and both flags = 0.
  - If motor_en = 0 in that cycle: duty_k = DUTY_INIT and all flags for k are cleared.
  - After the last channel, go to LOG.
- LOG (cycles t+1+NUM_CH .. t+2*NUM_CH): one record per cycle, channel 0 first.
  - Condition: motor_en = 1 and tlm_full = 0 in that cycle. When it holds, tlm_wr_en = 1 and tlm_din = record in the following cycle; write k occurs at t+2+NUM_CH+k.
  - tlm_full = 1 and motor_en = 1: no write, and tlm_drop_cnt increments.
  - motor_en = 0: no write, no drop.
  - After the last record, return to IDLE.
- Record format:
  - [63:56] channel index.
  - [55:40] snapshotted RPM, zero-extended.
  - [39:16] snapshotted raw correction, sign-extended to 24 bits.
  - [15:0] new duty, zero-extended.
- tlm_wr_en is a registered single-cycle pulse per record and is never high in IDLE except the final record's cycle.
- busy = (state != IDLE).
- update_en while busy: ignored (no snapshot, no restart) and sets overrun. overrun clears only on reset.
- Input lanes changing after the snapshot do not affect the current sequence.

Test Plan:
1. Reset with NUM_CH=2 and defaults -> duty_out lanes = 27000/27000, all flags 0, tlm_wr_en 0, busy 0, tlm_drop_cnt 0.
2. motor_en=1, correction ch0=+1000, ch1=-500, rpm 100/95, update_en pulse at t:
   - duty0 = 28000 from t+2; duty1 = 26500 from t+3.
   - tlm_wr_en at t+4 with tlm_din = {8'd0,16'd100,24'sd1000,16'd28000}.
   - tlm_wr_en at t+5 with tlm_din = {8'd1,16'd95,-24'sd500,16'd26500}.
   - busy high t+1..t+4.
3. Slew and saturation:
   - correction ch0 = +10000 -> duty0 = 31096, slew_hit[0] = 1.
   - Repeated updates with +4096 reach 49151 with sat_hi[0] = 1 and never exceed it.
   - duty 2000 with correction -4096 -> 0, sat_lo = 1.
4. tlm_full = 1 through LOG -> no tlm_wr_en, tlm_drop_cnt = 2, duty_out still updated.
5. update_en re-pulsed at t+2 -> ignored, overrun = 1 and sticky, sequence completes normally.
6. Robustness:
   - motor_en = 0 during UPDATE -> duty lanes = 27000, no records, no drops.
   - reset asserted mid-UPDATE -> next cycle all lanes 27000, IDLE, busy 0.

Source files
------------

// File: rtl/motor_duty_sequencer.sv
// Per-channel duty update sequencer: snapshots PID corrections on a control-rate
// strobe, slews/saturates each duty in turn, then streams one telemetry record per channel.
module motor_duty_sequencer #(
  parameter int NUM_CH         = 2,
  parameter int PWM_RESOLUTION = 16,
  parameter int RPM_RESOLUTION = 10,
  parameter int DUTY_INIT      = 27000,
  parameter int DUTY_MIN       = 0,
  parameter int DUTY_MAX       = 49151,
  parameter int SLEW_MAX       = 4096
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     update_en,
  input  logic                                     motor_en,
  input  logic [NUM_CH*(PWM_RESOLUTION+1)-1:0]     correction,
  input  logic [NUM_CH*RPM_RESOLUTION-1:0]         rpm_measured,
  output logic [NUM_CH*PWM_RESOLUTION-1:0]         duty_out,
  output logic [NUM_CH-1:0]                        sat_hi,
  output logic [NUM_CH-1:0]                        sat_lo,
  output logic [NUM_CH-1:0]                        slew_hit,
  output logic                                     busy,
  output logic                                     overrun,
  input  logic                                     tlm_full,
  output logic                                     tlm_wr_en,
  output logic [63:0]                              tlm_din,
  output logic [15:0]                              tlm_drop_cnt
);

  // state    | meaning
  // S_IDLE   | waiting for update_en; snapshot taken on the strobe
  // S_UPDATE | one channel per cycle: slew limit, add, saturate
  // S_LOG    | one telemetry record per cycle, channel 0 first

  localparam int PW   = PWM_RESOLUTION;
  localparam int RW   = RPM_RESOLUTION;
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW   = PW + 2;
  localparam int LAST = NUM_CH - 1;

  localparam logic signed [SW-1:0] SLEW_P = SW'(SLEW_MAX);
  localparam logic signed [SW-1:0] SLEW_N = SW'(-SLEW_MAX);
  localparam logic signed [SW-1:0] DMAX_S = SW'(DUTY_MAX);
  localparam logic signed [SW-1:0] DMIN_S = SW'(DUTY_MIN);

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_LOG} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic            snap;

  logic [PW:0]     corr_q [NUM_CH];
  logic [RW-1:0]   rpm_q  [NUM_CH];
  logic [PW-1:0]   duty_q [NUM_CH];
  logic [NUM_CH-1:0] sat_hi_q, sat_lo_q, slew_hit_q;
  logic            overrun_q;
  logic            wr_q;
  logic [63:0]     din_q;
  logic [15:0]     drop_q;

  logic [PW:0]            corr_cur;
  logic signed [SW-1:0]   corr_ext, corr_lim, sum;
  logic                   slew_c, hi_c, lo_c;
  logic [PW-1:0]          duty_new;
  logic [63:0]            rec;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (update_en) begin
          state_d = S_UPDATE;
          idx_d   = '0;
          snap    = 1'b1;
        end
      end
      S_UPDATE: begin
        if (idx_q == CW'(LAST)) begin
          state_d = S_LOG;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      S_LOG: begin
        if (idx_q == CW'(LAST)) begin
          state_d = S_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Sum is one bit wider than {0,duty} so a full-scale duty plus a positive
  // correction can never wrap before the saturation compare.
  always_comb begin
    corr_cur = corr_q[idx_q];
    corr_ext = $signed({corr_cur[PW], corr_cur});
    slew_c   = 1'b0;
    hi_c     = 1'b0;
    lo_c     = 1'b0;
    corr_lim = corr_ext;
    if (corr_ext > SLEW_P) begin
      corr_lim = SLEW_P;
      slew_c   = 1'b1;
    end else if (corr_ext < SLEW_N) begin
      corr_lim = SLEW_N;
      slew_c   = 1'b1;
    end
    sum = $signed({2'b00, duty_q[idx_q]}) + corr_lim;
    if (sum > DMAX_S) begin
      duty_new = PW'(DUTY_MAX);
      hi_c     = 1'b1;
    end else if (sum < DMIN_S) begin
      duty_new = PW'(DUTY_MIN);
      lo_c     = 1'b1;
    end else begin
      duty_new = sum[PW-1:0];
    end
    rec = {8'(idx_q), 16'(rpm_q[idx_q]), {(24-PW-1){corr_cur[PW]}}, corr_cur,
           16'(duty_q[idx_q])};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        corr_q[k] <= '0;
        rpm_q[k]  <= '0;
        duty_q[k] <= PW'(DUTY_INIT);
      end
      sat_hi_q   <= '0;
      sat_lo_q   <= '0;
      slew_hit_q <= '0;
      overrun_q  <= 1'b0;
      wr_q       <= 1'b0;
      din_q      <= '0;
      drop_q     <= '0;
    end else begin
      wr_q <= 1'b0;
      if (snap) begin
        for (int k = 0; k < NUM_CH; k++) begin
          corr_q[k] <= correction[k*(PW+1) +: PW+1];
          rpm_q[k]  <= rpm_measured[k*RW +: RW];
        end
      end
      if (update_en && (state_q != S_IDLE)) overrun_q <= 1'b1;
      if (state_q == S_UPDATE) begin
        if (motor_en) begin
          duty_q[idx_q]     <= duty_new;
          sat_hi_q[idx_q]   <= hi_c;
          sat_lo_q[idx_q]   <= lo_c;
          slew_hit_q[idx_q] <= slew_c;
        end else begin
          duty_q[idx_q]     <= PW'(DUTY_INIT);
          sat_hi_q[idx_q]   <= 1'b0;
          sat_lo_q[idx_q]   <= 1'b0;
          slew_hit_q[idx_q] <= 1'b0;
        end
      end
      if ((state_q == S_LOG) && motor_en) begin
        if (!tlm_full) begin
          wr_q  <= 1'b1;
          din_q <= rec;
        end else if (drop_q != 16'hFFFF) begin
          drop_q <= drop_q + 16'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    assign duty_out[g*PW +: PW] = duty_q[g];
  end

  assign sat_hi       = sat_hi_q;
  assign sat_lo       = sat_lo_q;
  assign slew_hit     = slew_hit_q;
  assign busy         = (state_q != S_IDLE);
  assign overrun      = overrun_q;
  assign tlm_wr_en    = wr_q;
  assign tlm_din      = din_q;
  assign tlm_drop_cnt = drop_q;

endmodule

// File: tb/tb_motor_duty_sequencer.sv
// Bench for motor_duty_sequencer: directed scenarios plus randomized updates,
// checked against an integer-arithmetic reference of the duty/telemetry rules.
module tb_motor_duty_sequencer;

  localparam int NUM_CH = 2;
  localparam int PW     = 16;
  localparam int RW     = 10;
  localparam int DI     = 27000;
  localparam int DMIN   = 0;
  localparam int DMAX   = 49151;
  localparam int SLEW   = 4096;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic                       update_en = 1'b0;
  logic                       motor_en = 1'b0;
  logic [NUM_CH*(PW+1)-1:0]   correction = '0;
  logic [NUM_CH*RW-1:0]       rpm_measured = '0;
  logic [NUM_CH*PW-1:0]       duty_out;
  logic [NUM_CH-1:0]          sat_hi, sat_lo, slew_hit;
  logic                       busy, overrun;
  logic                       tlm_full = 1'b0;
  logic                       tlm_wr_en;
  logic [63:0]                tlm_din;
  logic [15:0]                tlm_drop_cnt;

  motor_duty_sequencer #(
    .NUM_CH(NUM_CH), .PWM_RESOLUTION(PW), .RPM_RESOLUTION(RW),
    .DUTY_INIT(DI), .DUTY_MIN(DMIN), .DUTY_MAX(DMAX), .SLEW_MAX(SLEW)
  ) dut (
    .clk(clk), .reset(reset), .update_en(update_en), .motor_en(motor_en),
    .correction(correction), .rpm_measured(rpm_measured), .duty_out(duty_out),
    .sat_hi(sat_hi), .sat_lo(sat_lo), .slew_hit(slew_hit), .busy(busy),
    .overrun(overrun), .tlm_full(tlm_full), .tlm_wr_en(tlm_wr_en),
    .tlm_din(tlm_din), .tlm_drop_cnt(tlm_drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int duty_m [NUM_CH];
  bit hi_m [NUM_CH];
  bit lo_m [NUM_CH];
  bit sw_m [NUM_CH];
  int drop_m = 0;
  bit ovr_m = 1'b0;

  int corr_v [NUM_CH];
  int rpm_v  [NUM_CH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lane(input int k);
    return int'(duty_out[k*PW +: PW]);
  endfunction

  // Reference rule: clamp correction, add, saturate; disabled motor reloads the init duty.
  task automatic model_ch(input int duty, input int corr, input bit en,
                          output int nd, output bit hi, output bit lo, output bit sw);
    int c;
    int s;
    hi = 0; lo = 0; sw = 0;
    if (!en) begin
      nd = DI;
      return;
    end
    c = corr;
    if (c > SLEW) begin c = SLEW; sw = 1; end
    else if (c < -SLEW) begin c = -SLEW; sw = 1; end
    s = duty + c;
    if (s > DMAX) begin nd = DMAX; hi = 1; end
    else if (s < DMIN) begin nd = DMIN; lo = 1; end
    else nd = s;
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) begin
      duty_m[k] = DI; hi_m[k] = 0; lo_m[k] = 0; sw_m[k] = 0;
    end
    drop_m = 0;
    ovr_m  = 0;
  endtask

  task automatic check_idle(input string tag);
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("%s duty%0d", tag, k), 64'(lane(k)), 64'(duty_m[k]));
      chk($sformatf("%s flags%0d", tag, k), {61'd0, sat_hi[k], sat_lo[k], slew_hit[k]},
          {61'd0, hi_m[k], lo_m[k], sw_m[k]});
    end
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " wr_en"}, 64'(tlm_wr_en), 64'd0);
    chk({tag, " drop"}, 64'(tlm_drop_cnt), 64'(drop_m));
    chk({tag, " overrun"}, 64'(overrun), 64'(ovr_m));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    update_en = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_reset();
    check_idle("reset");
    chk("reset din", tlm_din, 64'd0);
  endtask

  task automatic run_update(input string tag, input bit en, input bit full, input bit repulse);
    int nd [NUM_CH];
    bit hi [NUM_CH];
    bit lo [NUM_CH];
    bit sw [NUM_CH];
    logic [63:0] rec [NUM_CH];
    bit exp_wr;
    for (int k = 0; k < NUM_CH; k++) begin
      correction[k*(PW+1) +: PW+1] = (PW+1)'(corr_v[k]);
      rpm_measured[k*RW +: RW]     = RW'(rpm_v[k]);
      model_ch(duty_m[k], corr_v[k], en, nd[k], hi[k], lo[k], sw[k]);
      rec[k] = {8'(k), 16'(rpm_v[k]), 24'(corr_v[k]), 16'(nd[k])};
    end
    motor_en  = en;
    tlm_full  = full;
    update_en = 1'b1;
    tick();
    update_en    = 1'b0;
    correction   = (NUM_CH*(PW+1))'({$urandom(), $urandom()});
    rpm_measured = (NUM_CH*RW)'($urandom());
    chk({tag, " busy start"}, 64'(busy), 64'd1);
    for (int j = 1; j <= 2*NUM_CH; j++) begin
      tick();
      for (int k = 0; k < NUM_CH; k++) begin
        if (j == 1 + k) begin
          chk($sformatf("%s duty%0d", tag, k), 64'(lane(k)), 64'(nd[k]));
          chk($sformatf("%s flags%0d", tag, k), {61'd0, sat_hi[k], sat_lo[k], slew_hit[k]},
              {61'd0, hi[k], lo[k], sw[k]});
        end
      end
      exp_wr = (j >= NUM_CH + 1) && en && !full;
      if ((j >= NUM_CH + 1) && en && full && (drop_m < 65535)) drop_m++;
      chk($sformatf("%s wr_en j%0d", tag, j), 64'(tlm_wr_en), 64'(exp_wr));
      if (exp_wr)
        chk($sformatf("%s din j%0d", tag, j), tlm_din, rec[j-NUM_CH-1]);
      chk($sformatf("%s busy j%0d", tag, j), 64'(busy), 64'(j < 2*NUM_CH));
      chk($sformatf("%s drop j%0d", tag, j), 64'(tlm_drop_cnt), 64'(drop_m));
      if (repulse) begin
        update_en = (j == 1);
        if (j == 1) ovr_m = 1'b1;
      end
    end
    for (int k = 0; k < NUM_CH; k++) begin
      duty_m[k] = nd[k]; hi_m[k] = hi[k]; lo_m[k] = lo[k]; sw_m[k] = sw[k];
    end
    tick();
    check_idle({tag, " end"});
  endtask

  initial begin
    model_reset();

    do_reset();

    corr_v = '{1000, -500};
    rpm_v  = '{100, 95};
    run_update("basic", 1, 0, 0);
    chk("basic duty0 abs", 64'(lane(0)), 64'd28000);
    chk("basic duty1 abs", 64'(lane(1)), 64'd26500);

    do_reset();
    corr_v = '{10000, 0};
    rpm_v  = '{1, 2};
    run_update("slew", 1, 0, 0);
    chk("slew duty0 abs", 64'(lane(0)), 64'd31096);
    chk("slew hit0", 64'(slew_hit[0]), 64'd1);
    corr_v = '{4096, 0};
    for (int i = 0; i < 6; i++) run_update("sathi", 1, 0, 0);
    chk("sathi duty0 abs", 64'(lane(0)), 64'd49151);
    chk("sathi flag0", 64'(sat_hi[0]), 64'd1);

    do_reset();
    corr_v = '{0, -4096};
    for (int i = 0; i < 6; i++) run_update("down", 1, 0, 0);
    corr_v = '{0, -424};
    run_update("to2000", 1, 0, 0);
    chk("to2000 duty1 abs", 64'(lane(1)), 64'd2000);
    corr_v = '{0, -4096};
    run_update("satlo", 1, 0, 0);
    chk("satlo duty1 abs", 64'(lane(1)), 64'd0);
    chk("satlo flag1", 64'(sat_lo[1]), 64'd1);

    do_reset();
    corr_v = '{100, 200};
    rpm_v  = '{7, 8};
    run_update("full", 1, 1, 0);
    chk("full drop abs", 64'(tlm_drop_cnt), 64'd2);
    chk("full duty0 abs", 64'(lane(0)), 64'd27100);

    corr_v = '{-300, 300};
    run_update("overrun", 1, 0, 1);
    chk("overrun set", 64'(overrun), 64'd1);
    run_update("overrun sticky", 1, 0, 0);
    chk("overrun still", 64'(overrun), 64'd1);

    corr_v = '{2000, -2000};
    run_update("disabled", 0, 0, 0);
    chk("disabled duty0 abs", 64'(lane(0)), 64'd27000);
    chk("disabled drop", 64'(tlm_drop_cnt), 64'(drop_m));

    corr_v = '{3000, 3000};
    run_update("pre-abort", 1, 0, 0);
    motor_en  = 1'b1;
    update_en = 1'b1;
    tick();
    update_en = 1'b0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check_idle("abort");

    for (int i = 0; i < 60; i++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if ($urandom_range(0, 3) == 0) corr_v[k] = int'($urandom_range(0, 131071)) - 65536;
        else corr_v[k] = int'($urandom_range(0, 12000)) - 6000;
        rpm_v[k] = int'($urandom_range(0, 1023));
      end
      run_update($sformatf("rnd%0d", i), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
